alu_nbit_seq: RTL and testbench

Parametrised, registered N-bit ALU; successor to the 1-bit ALU slice. Performs AND/OR/XOR/NOR/ADD/SUB/SLT in one cycle and an optional iterative shift-add unsigned multiply over WIDTH cycles. Uses a valid/ready handshake on input and output, and produces zero/carry/overflow/negative flags. Sits between the register-file read stage and writeback of the 24-bit CPU datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_nbit_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the N-bit sequential ALU: op encoding, FSM states, flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100,
    OP_XOR = 3'b101,
    OP_NOR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Latency: WIDTH cycles after i_start; o_done flags the cycle of the final step.
// Backpressure: none; the caller must not pulse i_start while o_busy is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Accumulator value after this cycle's step; on the last step it is the full product.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_busy    = (r_cnt != '0);
  assign o_done    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_nxt;

  // Load operands on start, then add/shift/decrement once per cycle until count hits zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered N-bit ALU (AND/OR/XOR/NOR/ADD/SUB/SLT, optional MUL via ALU_MUL_EN) with flags.
// Latency: 1 cycle for single-cycle ops; WIDTH+... i.e. result after WIDTH BUSY cycles for MUL.
// Backpressure: valid/ready both sides; result held in DONE until out_ready, accept overlaps consume.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                negative
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;

  alu_op_e          w_op;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_carry;
  logic             w_sc_ovf;

  logic             w_load;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;
  alu_flags_t       w_flags_nxt;

  assign w_op = alu_op_e'(op);

  // SUB and SLT share the adder as A + ~B + 1; carry out is then "no borrow".
  assign w_sub              = (w_op == OP_SUB) || (w_op == OP_SLT);
  assign w_b_eff            = w_sub ? ~b : b;
  assign {w_cout, w_sum}    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf              = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_MUL_EN
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`endif

  // Single-cycle result; MUL here is the unsupported-op marker used when no multiplier exists.
  always_comb begin
    w_sc_res   = '0;
    w_sc_carry = 1'b0;
    w_sc_ovf   = 1'b0;
    case (w_op)
      OP_AND: w_sc_res = a & b;
      OP_OR:  w_sc_res = a | b;
      OP_XOR: w_sc_res = a ^ b;
      OP_NOR: w_sc_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        w_sc_res   = w_sum;
        w_sc_carry = w_cout;
        w_sc_ovf   = w_ovf;
      end
      OP_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
      OP_MUL: w_sc_ovf = 1'b1;
      default: w_sc_res = '0;
    endcase
  end

  // Next state, handshake and result-load decision; DONE can consume and accept in one edge.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_load      = 1'b0;
    w_res_nxt   = w_sc_res;
    w_carry_nxt = w_sc_carry;
    w_ovf_nxt   = w_sc_ovf;
    w_flags_nxt = '0;
`ifdef ALU_MUL_EN
    w_mul_start = 1'b0;
`endif
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      ST_BUSY: begin
`ifdef ALU_MUL_EN
        if (w_mul_done) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res_nxt   = w_mul_prod[WIDTH-1:0];
          w_carry_nxt = 1'b0;
          w_ovf_nxt   = |w_mul_prod[2*WIDTH-1:WIDTH];
        end else if (!w_mul_busy) begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
      if (w_op == OP_MUL) begin
        w_mul_start = 1'b1;
        w_state_nxt = ST_BUSY;
      end else begin
        w_state_nxt = ST_DONE;
        w_load      = 1'b1;
      end
`else
      w_state_nxt = ST_DONE;
      w_load      = 1'b1;
`endif
    end
    w_flags_nxt.zero     = (w_res_nxt == '0);
    w_flags_nxt.carry    = w_carry_nxt;
    w_flags_nxt.overflow = w_ovf_nxt;
    w_flags_nxt.negative = w_res_nxt[WIDTH-1];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Result and flags only change when a new result is produced, so DONE holds them stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_load) begin
      r_result <= w_res_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_flags.zero;
  assign carry     = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign negative  = r_flags.negative;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq: directed literal cases plus randomized traffic against a behavioural model.
// The model tracks held result, pending multiply latency and handshake at transaction level.
// Inputs are driven 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_alu_nbit_seq;
  import alu_pkg::*;

  localparam int WIDTH = 24;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero, carry, overflow, negative;

  alu_nbit_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .negative(negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic: returns {result, zero, carry, overflow, negative}.
  function automatic logic [WIDTH+3:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic [2:0] o);
    longint lim, ux, uy, sx, sy, full, s;
    logic [WIDTH-1:0] r;
    logic c, v;
    lim = longint'(1) << WIDTH;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[WIDTH-1] ? ux - lim : ux;
    sy = y[WIDTH-1] ? uy - lim : uy;
    r = '0; c = 1'b0; v = 1'b0; full = 0; s = 0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b101: r = x ^ y;
      3'b110: r = ~(x | y);
      3'b010: begin
        full = ux + uy; r = full[WIDTH-1:0]; c = (full >= lim);
        s = sx + sy; v = (s >= lim / 2) || (s < -(lim / 2));
      end
      3'b011: begin
        full = ux - uy; r = full[WIDTH-1:0]; c = (ux >= uy);
        s = sx - sy; v = (s >= lim / 2) || (s < -(lim / 2));
      end
      3'b100: r[0] = (sx < sy);
      default: begin
        if (MUL_ON) begin
          full = ux * uy; r = full[WIDTH-1:0]; v = ((full >> WIDTH) != 0);
        end else begin
          r = '0; v = 1'b1;
        end
      end
    endcase
    return {r, (r == '0), c, v, r[WIDTH-1]};
  endfunction

  // Transaction-level model: a held result, or a multiply with a number of cycles still to go.
  logic             m_valid;
  int               m_busy;
  logic [WIDTH-1:0] m_res;
  logic [3:0]       m_flg;
  logic [WIDTH+3:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0; m_busy <= 0; m_res <= '0; m_flg <= '0; m_pend <= '0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1;
        {m_res, m_flg} <= m_pend;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (op == 3'b111 && MUL_ON) begin
        m_valid <= 1'b0; m_busy <= WIDTH; m_pend <= ref_op(a, b, op);
      end else begin
        m_valid <= 1'b1; {m_res, m_flg} <= ref_op(a, b, op);
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison of handshake and held result against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("model_in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_result", result, m_res);
        chk("model_flags", {zero, carry, overflow, negative}, m_flg);
      end
    end
  end

  // Present one op and hold it until accepted; returns at rising edge + 2.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] o);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; a = x; b = y; op = o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (got) begin @(posedge clk); #2; end
    in_valid = 1'b0;
    chk("issue_accepted", got, 1'b1);
  endtask

  // Wait for out_valid, then pin result/flags/latency to hand-computed literals; consumes the result.
  task automatic expect_lit(input string name, input logic [WIDTH-1:0] res, input logic [3:0] flg,
                            input int wait_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk({name, "_latency"}, n, wait_cycles);
    chk({name, "_result"}, result, res);
    chk({name, "_flags"}, {zero, carry, overflow, negative}, flg);
    @(posedge clk); #2;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(WIDTH-1){1'b1}}};
      3: return {1'b1, {(WIDTH-1){1'b0}}};
      4: return WIDTH'($urandom_range(15));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 3'b000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_result", result, 0);
    chk("reset_flags", {zero, carry, overflow, negative}, 4'b0000);
    @(posedge clk); #2;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Arithmetic and flag corners.
    issue(24'hFFFFFF, 24'h000001, 3'b010); expect_lit("add_wrap", 24'h000000, 4'b1100, 0);
    issue(24'h7FFFFF, 24'h000001, 3'b010); expect_lit("add_ovf", 24'h800000, 4'b0011, 0);
    issue(24'h000005, 24'h000007, 3'b011); expect_lit("sub_borrow", 24'hFFFFFE, 4'b0001, 0);
    issue(24'h800000, 24'h000001, 3'b100); expect_lit("slt_neg", 24'h000001, 4'b0000, 0);
    issue(24'h000005, 24'h000003, 3'b100); expect_lit("slt_pos", 24'h000000, 4'b1000, 0);
    issue(24'h7FFFFF, 24'h800000, 3'b100); expect_lit("slt_ovf", 24'h000000, 4'b1000, 0);
    issue(24'hF0F0F0, 24'h0FF00F, 3'b000); expect_lit("and", 24'h00F000, 4'b0000, 0);
    issue(24'hF0F0F0, 24'h0FF00F, 3'b001); expect_lit("or", 24'hFFF0FF, 4'b0001, 0);
    issue(24'hF0F0F0, 24'h0FF00F, 3'b101); expect_lit("xor", 24'hFF00FF, 4'b0001, 0);
    issue(24'hF0F0F0, 24'h0FF00F, 3'b110); expect_lit("nor", 24'h000F00, 4'b0000, 0);
`ifdef ALU_MUL_EN
    issue(24'd1234, 24'd5678, 3'b111); expect_lit("mul", 24'd7006652, 4'b0000, WIDTH);
    issue(24'h001000, 24'h001000, 3'b111); expect_lit("mul_ovf", 24'h000000, 4'b1010, WIDTH);
`else
    issue(24'd1234, 24'd5678, 3'b111); expect_lit("mul_unsupported", 24'h000000, 4'b1010, 0);
`endif

    // Backpressure: result held, new op ignored while the consumer stalls.
    out_ready = 1'b0;
    issue(24'd3, 24'd4, 3'b010);
    in_valid = 1'b1; a = 24'd9; b = 24'd9; op = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 24'd7);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1'b1);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_consumed", out_valid, 1'b0);
    @(posedge clk); #2;

    // Throughput: four ADDs on consecutive edges give four consecutive results.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = WIDTH'(10 + i); b = WIDTH'(i); op = 3'b010;
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_result", result, WIDTH'(10 + 2 * (i - 1)));
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", out_valid, 1'b1);
    chk("stream_last_result", result, 24'd16);
    @(posedge clk); #2;
    @(negedge clk);
    chk("stream_drained", out_valid, 1'b0);
    @(posedge clk); #2;

    // Reset in the middle of a multiply.
    issue(24'd1000, 24'd1000, 3'b111);
    @(posedge clk); #4;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {zero, carry, overflow, negative}, 4'b0000);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #4;
    reset = 1'b0;
    @(posedge clk); #2;
    issue(24'd1, 24'd1, 3'b010); expect_lit("post_reset_add", 24'd2, 4'b0000, 0);

    // Randomized traffic with random stalls on both sides.
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a = pick(); b = pick(); op = 3'(($urandom_range(7)));
      @(posedge clk); #2;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (WIDTH + 4) @(posedge clk);
    #2;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
